// File: rtl/axis_mult_arb_pkg.sv
// Shared types and sizes for the two-source AXIS multiplier arbiter.
package axis_mult_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STATS_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } state_t;

endpackage

// File: rtl/axis_mult_arb_oreg.sv
// Single-entry registered output stage for the multiplier result stream.
module axis_mult_arb_oreg
  import axis_mult_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              load_dest,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  output logic              m_axis_tdest,
  input  logic              m_axis_tready,
  output logic              out_rdy_c
);

  // Entry is free when empty or being drained this cycle.
  assign out_rdy_c = !m_axis_tvalid || m_axis_tready;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdest  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= load_data;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= load_last;
      m_axis_tdest  <= load_dest;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_mult_arb.sv
// Packet round-robin sharing of one combinational multiplier between two AXIS sources.
// Optional per-source packet counters when AXIS_MULT_ARB_STATS_EN is defined.
module axis_mult_arb
  import axis_mult_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic               aclk,
  input  logic               areset,
`ifdef AXIS_MULT_ARB_STATS_EN
  input  logic               stats_clr,
  output logic [STATS_W-1:0] pkt_cnt0,
  output logic [STATS_W-1:0] pkt_cnt1,
`endif
  input  logic [DATA_W-1:0]  s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  input  logic               s0_axis_tlast,
  output logic               s0_axis_tready,
  input  logic [DATA_W-1:0]  s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  input  logic               s1_axis_tlast,
  output logic               s1_axis_tready,
  output logic [DATA_W-1:0]  m_axis_tdata,
  output logic               m_axis_tvalid,
  output logic               m_axis_tlast,
  output logic               m_axis_tdest,
  input  logic               m_axis_tready,
  output logic [DATA_W-1:0]  mult_a,
  input  logic [DATA_W-1:0]  mult_r
);

  state_t state_q, state_d;
  logic   rr_last_q, rr_last_d;
  logic   out_rdy_c;
  logic   load_c, load_last_c, load_dest_c;

  // State and round-robin pointer; rr_last resets to 1 so source 0 wins first.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    case (state_q)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_d   = rr_last_q ? BUSY0 : BUSY1;
          rr_last_d = !rr_last_q;
        end else if (s0_axis_tvalid) begin
          state_d   = BUSY0;
          rr_last_d = 1'b0;
        end else if (s1_axis_tvalid) begin
          state_d   = BUSY1;
          rr_last_d = 1'b1;
        end
      end
      BUSY0:   if (load_c && s0_axis_tlast) state_d = IDLE;
      BUSY1:   if (load_c && s1_axis_tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Input mux and handshake for the granted source only.
  always_comb begin
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    mult_a         = '0;
    load_c         = 1'b0;
    load_last_c    = 1'b0;
    load_dest_c    = 1'b0;
    case (state_q)
      BUSY0: begin
        s0_axis_tready = out_rdy_c;
        mult_a         = s0_axis_tdata;
        load_c         = s0_axis_tvalid && out_rdy_c;
        load_last_c    = s0_axis_tlast;
      end
      BUSY1: begin
        s1_axis_tready = out_rdy_c;
        mult_a         = s1_axis_tdata;
        load_c         = s1_axis_tvalid && out_rdy_c;
        load_last_c    = s1_axis_tlast;
        load_dest_c    = 1'b1;
      end
      default: ;
    endcase
  end

  axis_mult_arb_oreg #(.DATA_W(DATA_W)) u_oreg (
    .aclk          (aclk),
    .areset        (areset),
    .load          (load_c),
    .load_data     (mult_r),
    .load_last     (load_last_c),
    .load_dest     (load_dest_c),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdest  (m_axis_tdest),
    .m_axis_tready (m_axis_tready),
    .out_rdy_c     (out_rdy_c)
  );

`ifdef AXIS_MULT_ARB_STATS_EN
  // Accepted tlast beats per source; clear wins over a same-cycle increment.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (stats_clr) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else if (load_c && load_last_c) begin
      if (load_dest_c) pkt_cnt1 <= pkt_cnt1 + STATS_W'(1);
      else             pkt_cnt0 <= pkt_cnt0 + STATS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_axis_mult_arb.sv
// Scoreboard bench for axis_mult_arb; multiplier modelled as r = a*3 mod 2^32.
module tb_axis_mult_arb;

  localparam int unsigned DATA_W = 32;

  logic              aclk = 1'b0;
  logic              areset;
  logic [DATA_W-1:0] s0_tdata, s1_tdata;
  logic              s0_tvalid, s0_tlast, s0_tready;
  logic              s1_tvalid, s1_tlast, s1_tready;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid, m_tlast, m_tdest, m_tready;
  logic [DATA_W-1:0] mult_a, mult_r;
`ifdef AXIS_MULT_ARB_STATS_EN
  logic              stats_clr;
  logic [15:0]       pkt_cnt0, pkt_cnt1;
`endif

  axis_mult_arb #(.DATA_W(DATA_W)) dut (
    .aclk           (aclk),
    .areset         (areset),
`ifdef AXIS_MULT_ARB_STATS_EN
    .stats_clr      (stats_clr),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
`endif
    .s0_axis_tdata  (s0_tdata),
    .s0_axis_tvalid (s0_tvalid),
    .s0_axis_tlast  (s0_tlast),
    .s0_axis_tready (s0_tready),
    .s1_axis_tdata  (s1_tdata),
    .s1_axis_tvalid (s1_tvalid),
    .s1_axis_tlast  (s1_tlast),
    .s1_axis_tready (s1_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tlast   (m_tlast),
    .m_axis_tdest   (m_tdest),
    .m_axis_tready  (m_tready),
    .mult_a         (mult_a),
    .mult_r         (mult_r)
  );

  always #5 aclk = ~aclk;

  assign mult_r = mult_a * 32'd3;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W:0]   q0[$];   // {data, last}
  logic [DATA_W:0]   q1[$];
  logic [DATA_W+1:0] sb[$];   // {data, last, dest}
  bit acc0 = 1'b0;
  bit acc1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_beat(input logic [DATA_W-1:0] d, input logic l, input logic dst);
    sb.push_back({d, l, dst});
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < budget) begin
      @(negedge aclk);
      n++;
    end
    check("drain_timeout", 64'(n >= budget), 64'd0);
    repeat (2) @(negedge aclk);
  endtask

  // Handshake sampling away from the edge, used by the source drivers.
  always @(negedge aclk) begin
    acc0 = s0_tvalid && s0_tready;
    acc1 = s1_tvalid && s1_tready;
  end

  // Source drivers: present queue head, advance after an accepted beat.
  initial begin
    s0_tvalid = 1'b0; s0_tdata = '0; s0_tlast = 1'b0;
    s1_tvalid = 1'b0; s1_tdata = '0; s1_tlast = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (acc0 && q0.size() != 0) void'(q0.pop_front());
      if (acc1 && q1.size() != 0) void'(q1.pop_front());
      s0_tvalid = (q0.size() != 0);
      {s0_tdata, s0_tlast} = (q0.size() != 0) ? q0[0] : '0;
      s1_tvalid = (q1.size() != 0);
      {s1_tdata, s1_tlast} = (q1.size() != 0) ? q1[0] : '0;
    end
  end

  // Monitor: every output handshake pops and compares against the scoreboard.
  always @(negedge aclk) begin
    if (!areset && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", {30'd0, m_tdata, m_tlast, m_tdest}, 64'hDEAD);
      end else begin
        check("out_beat", {30'd0, m_tdata, m_tlast, m_tdest}, {30'd0, sb.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [23:0] pat24;
  logic [5:0]  pat6;

  initial begin
    areset   = 1'b1;
    m_tready = 1'b1;
`ifdef AXIS_MULT_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(negedge aclk);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_fields", {31'd0, m_tdata, m_tlast}, 64'd0);
    check("rst_m_tdest", 64'(m_tdest), 64'd0);
    check("rst_treadys", {62'd0, s0_tready, s1_tready}, 64'd0);
    check("rst_mult_a", 64'(mult_a), 64'd0);
    areset = 1'b0;
    @(negedge aclk);

    // 1: three-beat packet on s0, latency and ordering
    q0.push_back({32'd1, 1'b0}); q0.push_back({32'd2, 1'b0}); q0.push_back({32'd3, 1'b1});
    exp_beat(32'd3, 1'b0, 1'b0); exp_beat(32'd6, 1'b0, 1'b0); exp_beat(32'd9, 1'b1, 1'b0);
    @(negedge aclk);
    check("t1_idle_tready", 64'(s0_tready), 64'd0);
    @(negedge aclk);
    check("t1_busy_tready", 64'(s0_tready), 64'd1);
    check("t1_mult_a", 64'(mult_a), 64'd1);
    check("t1_no_out_yet", 64'(m_tvalid), 64'd0);
    @(negedge aclk);
    check("t1_latency", 64'(m_tvalid), 64'd1);
    wait_drain(50);

    // 2: both sources valid from reset, alternating 2-beat packets
    areset = 1'b1;
    q0.push_back({32'd10, 1'b0}); q0.push_back({32'd11, 1'b1});
    q0.push_back({32'd12, 1'b0}); q0.push_back({32'd13, 1'b1});
    q1.push_back({32'd20, 1'b0}); q1.push_back({32'd21, 1'b1});
    q1.push_back({32'd22, 1'b0}); q1.push_back({32'd23, 1'b1});
    exp_beat(32'd30, 1'b0, 1'b0); exp_beat(32'd33, 1'b1, 1'b0);
    exp_beat(32'd60, 1'b0, 1'b1); exp_beat(32'd63, 1'b1, 1'b1);
    exp_beat(32'd36, 1'b0, 1'b0); exp_beat(32'd39, 1'b1, 1'b0);
    exp_beat(32'd66, 1'b0, 1'b1); exp_beat(32'd69, 1'b1, 1'b1);
    repeat (2) @(negedge aclk);
    areset = 1'b0;
    pat24 = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      pat24 = {pat24[21:0], s0_tready, s1_tready};
    end
    check("t2_grant_pattern", 64'(pat24), 64'b10_10_00_01_01_00_10_10_00_01_01_00);
    wait_drain(50);

    // 3: output stall mid-packet on s1
    q1.push_back({32'd100, 1'b0}); q1.push_back({32'd101, 1'b0}); q1.push_back({32'd102, 1'b1});
    exp_beat(32'd300, 1'b0, 1'b1); exp_beat(32'd303, 1'b0, 1'b1); exp_beat(32'd306, 1'b1, 1'b1);
    @(negedge aclk);
    @(negedge aclk);
    check("t3_s1_tready", 64'(s1_tready), 64'd1);
    @(posedge aclk); #1 m_tready = 1'b0;
    @(negedge aclk);
    check("t3_stall_beat", {31'd0, m_tvalid, m_tdata}, {31'd1, 32'd300});
    check("t3_stall_tready", 64'(s1_tready), 64'd0);
    @(negedge aclk);
    check("t3_hold_beat", {31'd0, m_tvalid, m_tdata}, {31'd1, 32'd300});
    check("t3_hold_tready", 64'(s1_tready), 64'd0);
    @(posedge aclk); #1 m_tready = 1'b1;
    wait_drain(50);

    // 4: single-beat packets on s1, one output every two cycles
    for (int i = 0; i < 3; i++) begin
      q1.push_back({32'hFFFF_FFFF, 1'b1});
      exp_beat(32'hFFFF_FFFD, 1'b1, 1'b1);
    end
    @(negedge aclk);
    pat6 = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      pat6 = {pat6[4:0], m_tvalid};
    end
    check("t4_valid_pattern", 64'(pat6), 64'b010101);
    wait_drain(50);

    // 5: reset mid-packet on s0, then src0 wins the next arbitration
    q0.push_back({32'd5, 1'b0}); q0.push_back({32'd6, 1'b0}); q0.push_back({32'd7, 1'b1});
    exp_beat(32'd15, 1'b0, 1'b0);
    repeat (3) @(negedge aclk);
    @(posedge aclk); #3 areset = 1'b1;
    #1;
    check("t5_rst_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_rst_tready", 64'(s0_tready), 64'd0);
    q0.delete();
    @(negedge aclk);
    q0.push_back({32'd40, 1'b1});
    q1.push_back({32'd50, 1'b1});
    exp_beat(32'd120, 1'b1, 1'b0); exp_beat(32'd150, 1'b1, 1'b1);
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    check("t5_src0_first", {62'd0, s0_tready, s1_tready}, 64'b10);
    wait_drain(50);

`ifdef AXIS_MULT_ARB_STATS_EN
    // 6: packet counters, clear and wrap
    stats_clr = 1'b1;
    @(negedge aclk);
    stats_clr = 1'b0;
    q0.push_back({32'd1, 1'b1}); q0.push_back({32'd2, 1'b1}); q0.push_back({32'd3, 1'b1});
    q1.push_back({32'd4, 1'b1}); q1.push_back({32'd5, 1'b1});
    exp_beat(32'd3, 1'b1, 1'b0); exp_beat(32'd12, 1'b1, 1'b1);
    exp_beat(32'd6, 1'b1, 1'b0); exp_beat(32'd15, 1'b1, 1'b1);
    exp_beat(32'd9, 1'b1, 1'b0);
    wait_drain(80);
    check("t6_cnt0", 64'(pkt_cnt0), 64'd3);
    check("t6_cnt1", 64'(pkt_cnt1), 64'd2);
    stats_clr = 1'b1;
    @(negedge aclk);
    stats_clr = 1'b0;
    check("t6_clr", {32'd0, pkt_cnt0, pkt_cnt1}, 64'd0);
    force dut.pkt_cnt0 = 16'hFFFF;
    @(negedge aclk);
    release dut.pkt_cnt0;
    q0.push_back({32'd7, 1'b1});
    exp_beat(32'd21, 1'b1, 1'b0);
    wait_drain(50);
    check("t6_wrap", 64'(pkt_cnt0), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
